// File: rtl/prim_ram_port_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : prim_ram_port_pkg
// Brief    : Shared types for the RAM-port host controller.
// Revision : 1.0
// ----------------------------------------------------------------------------
package prim_ram_port_pkg;

  typedef enum logic [0:0] {
    RpWipe  = 1'b0,
    RpReady = 1'b1
  } ram_port_state_e;

endpackage
`default_nettype wire

// File: rtl/prim_ram_port_host.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : prim_ram_port_host
// Brief    : Host req/gnt/rvalid to single RAM port adapter with wipe sequencer.
// Revision : 1.0
// ----------------------------------------------------------------------------
module prim_ram_port_host
  import prim_ram_port_pkg::*;
#(
  parameter int unsigned      Width           = 32,
  parameter int unsigned      Depth           = 128,
  parameter int unsigned      DataBitsPerMask = 1,
  parameter bit               InitOnReset     = 1'b1,
  parameter logic [Width-1:0] WipeData        = '0,
  localparam int unsigned     Aw              = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  output logic             gnt_o,
  input  logic             we_i,
  input  logic [Aw-1:0]    addr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [Width-1:0] wmask_i,
  output logic             rvalid_o,
  output logic [Width-1:0] rdata_o,
  output logic             rerror_o,
  input  logic             wipe_req_i,
  output logic             busy_o,
  output logic             wipe_done_o,
  output logic             ram_req_o,
  output logic             ram_write_o,
  output logic [Aw-1:0]    ram_addr_o,
  output logic [Width-1:0] ram_wdata_o,
  output logic [Width-1:0] ram_wmask_o,
  input  logic [Width-1:0] ram_rdata_i
);

  typedef struct packed {
    logic             req;
    logic             write;
    logic [Aw-1:0]    addr;
    logic [Width-1:0] wdata;
    logic [Width-1:0] wmask;
  } ram_port_req_t;

  localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);

  ram_port_state_e state_q, state_d;
  logic [Aw-1:0]   cnt_q, cnt_d;
  logic            rd_pending_q, rd_pending_d;
  logic            rd_err_q, rd_err_d;
  ram_port_req_t   ram_req;
  logic            addr_in_range;

  assign addr_in_range = 32'(addr_i) < Depth;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= InitOnReset ? RpWipe : RpReady;
      cnt_q        <= '0;
      rd_pending_q <= 1'b0;
      rd_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_pending_q <= rd_pending_d;
      rd_err_q     <= rd_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ram_req      = '0;
    gnt_o        = 1'b0;
    wipe_done_o  = 1'b0;
    rd_pending_d = 1'b0;
    rd_err_d     = 1'b0;
    unique case (state_q)
      RpWipe: begin
        ram_req.req   = 1'b1;
        ram_req.write = 1'b1;
        ram_req.addr  = cnt_q;
        ram_req.wdata = WipeData;
        ram_req.wmask = '1;
        if (cnt_q == LastAddr) begin
          wipe_done_o = 1'b1;
          state_d     = RpReady;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RpReady: begin
        // A wipe request steals the cycle from the host outright.
        if (wipe_req_i) begin
          state_d = RpWipe;
        end else if (req_i) begin
          gnt_o = 1'b1;
          if (addr_in_range) begin
            ram_req.req   = 1'b1;
            ram_req.write = we_i;
            ram_req.addr  = addr_i;
            ram_req.wdata = wdata_i;
            ram_req.wmask = wmask_i;
          end
          rd_pending_d = ~we_i;
          rd_err_d     = ~we_i & ~addr_in_range;
        end
      end
    endcase
  end

  assign ram_req_o   = ram_req.req;
  assign ram_write_o = ram_req.write;
  assign ram_addr_o  = ram_req.addr;
  assign ram_wdata_o = ram_req.wdata;
  assign ram_wmask_o = ram_req.wmask;

  assign busy_o   = (state_q == RpWipe);
  assign rvalid_o = rd_pending_q;
  assign rerror_o = rd_pending_q & rd_err_q;
  assign rdata_o  = (rd_pending_q && !rd_err_q) ? ram_rdata_i : '0;

`ifndef SYNTHESIS
  for (genvar g = 0; g < Width / DataBitsPerMask; g++) begin : g_wmask_chk
    assert property (@(posedge clk_i) disable iff (!rst_ni)
      (gnt_o && we_i) |->
        ((wmask_i[g*DataBitsPerMask +: DataBitsPerMask] == {DataBitsPerMask{1'b0}}) ||
         (wmask_i[g*DataBitsPerMask +: DataBitsPerMask] == {DataBitsPerMask{1'b1}})));
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni)
    (gnt_o && we_i) |=> !rvalid_o);

  assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == RpWipe) |-> !gnt_o);
`endif

endmodule
`default_nettype wire

// File: tb/tb_prim_ram_port_host.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_prim_ram_port_host
// Brief    : Scoreboard bench for prim_ram_port_host (Depth 128 wipe-on-reset, Depth 100 no-wipe).
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_prim_ram_port_host;

  localparam logic [31:0] WIPE = 32'hA5A5A5A5;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        we;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [31:0] wmask;
    logic        exp_gnt;
    logic        exp_ram_req;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  // Instance A: Depth 128, wipe on reset
  logic        req_a, gnt_a, we_a, rvalid_a, rerror_a, wipe_a, busy_a, done_a;
  logic [6:0]  addr_a, ram_addr_a;
  logic [31:0] wdata_a, wmask_a, rdata_a, ram_wdata_a, ram_wmask_a, ram_rdata_a;
  logic        ram_req_a, ram_write_a;

  // Instance B: Depth 100, starts Ready
  logic        req_b, gnt_b, we_b, rvalid_b, rerror_b, wipe_b, busy_b, done_b;
  logic [6:0]  addr_b, ram_addr_b;
  logic [31:0] wdata_b, wmask_b, rdata_b, ram_wdata_b, ram_wmask_b, ram_rdata_b;
  logic        ram_req_b, ram_write_b;

  prim_ram_port_host #(
    .Width(32), .Depth(128), .DataBitsPerMask(1), .InitOnReset(1'b1), .WipeData(WIPE)
  ) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_a), .gnt_o(gnt_a), .we_i(we_a),
    .addr_i(addr_a), .wdata_i(wdata_a), .wmask_i(wmask_a), .rvalid_o(rvalid_a),
    .rdata_o(rdata_a), .rerror_o(rerror_a), .wipe_req_i(wipe_a), .busy_o(busy_a),
    .wipe_done_o(done_a), .ram_req_o(ram_req_a), .ram_write_o(ram_write_a),
    .ram_addr_o(ram_addr_a), .ram_wdata_o(ram_wdata_a), .ram_wmask_o(ram_wmask_a),
    .ram_rdata_i(ram_rdata_a)
  );

  prim_ram_port_host #(
    .Width(32), .Depth(100), .DataBitsPerMask(1), .InitOnReset(1'b0), .WipeData(32'h0)
  ) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_b), .gnt_o(gnt_b), .we_i(we_b),
    .addr_i(addr_b), .wdata_i(wdata_b), .wmask_i(wmask_b), .rvalid_o(rvalid_b),
    .rdata_o(rdata_b), .rerror_o(rerror_b), .wipe_req_i(wipe_b), .busy_o(busy_b),
    .wipe_done_o(done_b), .ram_req_o(ram_req_b), .ram_write_o(ram_write_b),
    .ram_addr_o(ram_addr_b), .ram_wdata_o(ram_wdata_b), .ram_wmask_o(ram_wmask_b),
    .ram_rdata_i(ram_rdata_b)
  );

  // RAM models: masked write, registered read data
  logic [31:0] mem_a [0:127];
  logic [31:0] mem_b [0:99];

  always @(posedge clk) begin
    if (ram_req_a) begin
      if (ram_write_a)
        mem_a[ram_addr_a] <= (mem_a[ram_addr_a] & ~ram_wmask_a) | (ram_wdata_a & ram_wmask_a);
      else
        ram_rdata_a <= mem_a[ram_addr_a];
    end
  end

  always @(posedge clk) begin
    if (ram_req_b && (int'(ram_addr_b) < 100)) begin
      if (ram_write_b)
        mem_b[ram_addr_b] <= (mem_b[ram_addr_b] & ~ram_wmask_b) | (ram_wdata_b & ram_wmask_b);
      else
        ram_rdata_b <= mem_b[ram_addr_b];
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference state for instance A
  logic [31:0] ref_a [0:127];
  exp_t        q_a[$];
  exp_t        e_a;
  bit          pend_a;
  bit          wst_a;
  int          wcnt_a;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      q_a.delete();
      pend_a = 1'b0;
      wst_a  = 1'b1;
      wcnt_a = 0;
    end else begin
      check("a_rvalid", rvalid_a, pend_a);
      if (pend_a) begin
        e_a = q_a.pop_front();
        check("a_rdata", rdata_a, e_a.data);
        check("a_rerror", rerror_a, e_a.err);
      end else begin
        check("a_rdata_idle", {rerror_a, rdata_a}, 0);
      end
      pend_a = 1'b0;
      check("a_busy", busy_a, wst_a);
      if (wst_a) begin
        check("a_wipe_gnt", gnt_a, 0);
        check("a_wipe_port", {ram_req_a, ram_write_a, ram_addr_a, ram_wdata_a, ram_wmask_a},
              {1'b1, 1'b1, 7'(wcnt_a), WIPE, 32'hFFFF_FFFF});
        check("a_wipe_done", done_a, (wcnt_a == 127));
        ref_a[wcnt_a] = WIPE;
        if (wcnt_a == 127) begin
          wst_a  = 1'b0;
          wcnt_a = 0;
        end else begin
          wcnt_a++;
        end
      end else begin
        check("a_done_idle", done_a, 0);
        check("a_gnt", gnt_a, (req_a && !wipe_a));
        if (req_a && !wipe_a) begin
          check("a_port", {ram_req_a, ram_write_a, ram_addr_a, ram_wdata_a, ram_wmask_a},
                {1'b1, we_a, addr_a, wdata_a, wmask_a});
          if (we_a) begin
            ref_a[addr_a] = (ref_a[addr_a] & ~wmask_a) | (wdata_a & wmask_a);
          end else begin
            q_a.push_back({1'b0, ref_a[addr_a]});
            pend_a = 1'b1;
          end
        end else begin
          check("a_port_idle", ram_req_a, 0);
        end
        if (wipe_a) wst_a = 1'b1;
      end
    end
  end

  // Reference state for instance B (never wiped)
  logic [31:0] ref_b [0:99];
  exp_t        q_b[$];
  exp_t        e_b;
  bit          pend_b;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      q_b.delete();
      pend_b = 1'b0;
    end else begin
      check("b_rvalid", rvalid_b, pend_b);
      if (pend_b) begin
        e_b = q_b.pop_front();
        check("b_rdata", rdata_b, e_b.data);
        check("b_rerror", rerror_b, e_b.err);
      end else begin
        check("b_rdata_idle", {rerror_b, rdata_b}, 0);
      end
      pend_b = 1'b0;
      check("b_busy", busy_b, 0);
      check("b_gnt", gnt_b, req_b);
      if (req_b) begin
        if (int'(addr_b) < 100) begin
          check("b_port", {ram_req_b, ram_write_b, ram_addr_b, ram_wdata_b, ram_wmask_b},
                {1'b1, we_b, addr_b, wdata_b, wmask_b});
          if (we_b) ref_b[addr_b] = (ref_b[addr_b] & ~wmask_b) | (wdata_b & wmask_b);
          else      q_b.push_back({1'b0, ref_b[addr_b]});
        end else begin
          check("b_oor_ram_req", ram_req_b, 0);
          if (!we_b) q_b.push_back({1'b1, 32'h0});
        end
        pend_b = !we_b;
      end else begin
        check("b_port_idle", ram_req_b, 0);
      end
    end
  end

  task automatic host_a(input logic we, input logic [6:0] addr, input logic [31:0] d, input logic [31:0] m);
    req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = d; wmask_a = m;
    @(posedge clk); #1;
    req_a = 1'b0; we_a = 1'b0; wdata_a = '0; wmask_a = '0;
  endtask

  task automatic resp_check_a(input string name, input logic [31:0] exp);
    @(negedge clk);
    check(name, {rvalid_a, rdata_a}, {1'b1, exp});
    @(posedge clk); #1;
  endtask

  task automatic wait_idle_a(input int budget);
    int n = 0;
    while (busy_a && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (busy_a) begin
      errors++;
      $display("FAIL a_wipe_timeout: busy_o still 1 after %0d cycles, required 0", budget);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  vec_t vecs [10];

  initial begin
    vecs[0] = '{1'b1, 7'd10,  32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 7'd99,  32'hCAFE_F00D, 32'hFFFF_FFFF, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 7'd10,  32'h0,         32'h0,         1'b1, 1'b1};
    vecs[3] = '{1'b0, 7'd99,  32'h0,         32'h0,         1'b1, 1'b1};
    vecs[4] = '{1'b0, 7'd110, 32'h0,         32'h0,         1'b1, 1'b0};
    vecs[5] = '{1'b1, 7'd120, 32'h5555_5555, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 7'd100, 32'h0,         32'h0,         1'b1, 1'b0};
    vecs[7] = '{1'b1, 7'd10,  32'hFFFF_FFFF, 32'h00FF_00FF, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 7'd10,  32'h0,         32'h0,         1'b1, 1'b1};
    vecs[9] = '{1'b0, 7'd127, 32'h0,         32'h0,         1'b1, 1'b0};

    rst_n = 1'b0;
    req_a = 0; we_a = 0; addr_a = 0; wdata_a = 0; wmask_a = 0; wipe_a = 0;
    req_b = 0; we_b = 0; addr_b = 0; wdata_b = 0; wmask_b = 0; wipe_b = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_outs", {rvalid_a, rerror_a, gnt_a, done_a, busy_a}, 5'b00001);
    check("rst_b_outs", {rvalid_b, rerror_b, gnt_b, done_b, busy_b, ram_req_b}, 6'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset partway through the power-on wipe
    repeat (40) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("rst_mid_wipe", {busy_a, ram_addr_a, rvalid_a}, {1'b1, 7'd0, 1'b0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_idle_a(300);

    host_a(1'b0, 7'd77, 32'h0, 32'h0);
    resp_check_a("a_read77", WIPE);

    host_a(1'b1, 7'd5, 32'h0, 32'hFFFF_FFFF);
    host_a(1'b1, 7'd5, 32'hDEAD_BEEF, 32'h0000_FFFF);
    host_a(1'b0, 7'd5, 32'h0, 32'h0);
    resp_check_a("a_masked_rd", 32'h0000_BEEF);

    host_a(1'b1, 7'd1, 32'h1111_1111, 32'hFFFF_FFFF);
    host_a(1'b1, 7'd2, 32'h2222_2222, 32'hFFFF_FFFF);
    host_a(1'b1, 7'd3, 32'h3333_3333, 32'hFFFF_FFFF);
    host_a(1'b0, 7'd1, 32'h0, 32'h0);
    host_a(1'b0, 7'd2, 32'h0, 32'h0);
    host_a(1'b0, 7'd3, 32'h0, 32'h0);
    resp_check_a("a_rd3_b2b", 32'h3333_3333);

    // Wipe request right behind a granted read
    req_a = 1'b1; we_a = 1'b0; addr_a = 7'd3;
    @(posedge clk); #1;
    wipe_a = 1'b1;
    @(negedge clk);
    check("a_wipe_blocks_gnt", gnt_a, 0);
    check("a_rd_before_wipe", {rvalid_a, rdata_a, busy_a}, {1'b1, 32'h3333_3333, 1'b0});
    @(posedge clk); #1;
    wipe_a = 1'b0; req_a = 1'b0;
    @(negedge clk);
    check("a_busy_after_req", busy_a, 1);
    @(posedge clk); #1;
    wait_idle_a(300);
    host_a(1'b0, 7'd3, 32'h0, 32'h0);
    resp_check_a("a_rd3_wiped", WIPE);

    // Wipe request held across completion, host read blocked throughout
    wipe_a = 1'b1; req_a = 1'b1; we_a = 1'b0; addr_a = 7'd0;
    repeat (300) @(posedge clk);
    #1 wipe_a = 1'b0; req_a = 1'b0;
    wait_idle_a(300);

    for (int i = 0; i < 10; i++) begin
      req_b = 1'b1; we_b = vecs[i].we; addr_b = vecs[i].addr;
      wdata_b = vecs[i].wdata; wmask_b = vecs[i].wmask;
      @(negedge clk);
      check($sformatf("b_vec%0d_gnt", i), gnt_b, vecs[i].exp_gnt);
      check($sformatf("b_vec%0d_ram_req", i), ram_req_b, vecs[i].exp_ram_req);
      @(posedge clk); #1;
    end
    req_b = 1'b0; we_b = 1'b0; wdata_b = '0; wmask_b = '0;
    @(negedge clk);
    check("b_last_oor_resp", {rvalid_b, rerror_b, rdata_b}, {1'b1, 1'b1, 32'h0});

    repeat (4) @(posedge clk);
    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prim_ram_port_host.md
Name: prim_ram_port_host

Overview:
- Initiator-side controller that drives one port of the generic 2-port RAM: req/write/addr/wdata/wmask out, rdata in, fixed 1-cycle read latency.
- Converts a host req/gnt/rvalid handshake into RAM port cycles and generates rvalid for every granted read.
- Contains a wipe sequencer that writes WipeData to every word after reset (optional) or on request, blocking host traffic meanwhile.
- Sits between a bus adapter or DMA and one RAM port; two instances serve ports A and B.

Parameters:
- Width, 32, data width in bits.
- Depth, 128, number of words; need not be a power of 2.
- DataBitsPerMask, 1, data bits per mask group; the host wmask is always full bit-width.
- InitOnReset, 1, when 1, leave reset in Wipe; when 0, leave reset in Ready.
- WipeData, '0, Width-bit word written by the wipe sequencer.
- Aw, $clog2(Depth), localparam, address width.

Ports:
- clk_i  in  1  clock (single clock domain).
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  1  host request.
- gnt_o  out  1  request accepted this cycle.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  Aw  word address.
- wdata_i  in  Width  write data.
- wmask_i  in  Width  bit write mask.
- rvalid_o  out  1  read response valid; exactly 1 cycle after the granted read.
- rdata_o  out  Width  read data, valid with rvalid_o.
- rerror_o  out  1  out-of-range read, valid with rvalid_o.
- wipe_req_i  in  1  start wipe (level-sampled).
- busy_o  out  1  wipe in progress.
- wipe_done_o  out  1  one-cycle pulse when the last wipe write issues.
- ram_req_o  out  1  to RAM req.
- ram_write_o  out  1  to RAM write.
- ram_addr_o  out  Aw  to RAM addr.
- ram_wdata_o  out  Width  to RAM wdata.
- ram_wmask_o  out  Width  to RAM wmask.
- ram_rdata_i  in  Width  from RAM rdata.

Behaviour:
- FSM states:
  - Wipe: counter walks 0..Depth-1, one write per cycle. ram_req_o=1, ram_write_o=1, ram_wmask_o=all ones, ram_wdata_o=WipeData. On count Depth-1: pulse wipe_done_o, go to Ready, clear counter.
  - Ready: host passthrough.
- Reset values:
  - State = Wipe if InitOnReset, else Ready.
  - Counter = 0.
  - rvalid_o, rerror_o, wipe_done_o, gnt_o = 0.
  - busy_o = InitOnReset.
  - All ram_* outputs are driven combinationally from state and inputs; with no host request in Ready they are 0.
- gnt_o = req_i & (state==Ready) & ~wipe_req_i. Grant is combinational; there is no backpressure on responses.
- Granted in-range access (addr_i < Depth): same-cycle ram_req_o=1, ram_write_o=we_i, ram_addr_o=addr_i, ram_wdata_o=wdata_i, ram_wmask_o=wmask_i.
- Granted read: registered rd_pending=1. Next cycle rvalid_o=1 and rdata_o=ram_rdata_i (combinational passthrough of the RAM output register). Back-to-back reads give rvalid every cycle.
- Granted write: no response. rvalid_o is never asserted for writes.
- Out-of-range access (addr_i >= Depth, only possible when Depth is not a power of 2):
  - Still granted, but ram_req_o=0.
  - A read gets rvalid_o next cycle with rdata_o='0 and rerror_o=1.
  - A write is silently dropped.
- rerror_o=0 for every in-range response; rdata_o='0 whenever rvalid_o=0.
- wipe_req_i in Ready: host is not granted that cycle and state goes to Wipe next cycle. A read granted in the previous cycle still returns rvalid in this cycle, because ram_rdata_i is already registered.
- wipe_req_i during Wipe: ignored; no restart.
- wipe_req_i held high through completion: re-enter Wipe after exactly 1 Ready cycle. That cycle has no grant because wipe_req_i blocks gnt_o.
- busy_o = (state==Wipe).
- Counter width is Aw. The terminal compare is against Depth-1, so there is no wrap for non-power-of-2 Depth.
- Reset asserted mid-wipe or mid-read: outputs return to reset values immediately, any pending rvalid is discarded, and the wipe restarts from 0 if InitOnReset.
- Assert (simulation only):
  - host wmask_i is group-uniform per DataBitsPerMask;
  - rvalid_o never follows a write;
  - gnt_o never asserts in Wipe.

Decomposition:
- Package prim_ram_port_pkg:
  - enum ram_port_state_e {RpWipe, RpReady};
  - a packed struct ram_port_req_t {req, write, addr, wdata, wmask}, parameterised via typedef in the instantiating module for width flexibility.
- No sub-module. The counter and FSM are small and stay inline.

Test Plan:
- Reset, InitOnReset=1, Depth=128, WipeData=32'hA5A5A5A5 -> ram writes to addr 0..127 in 128 consecutive cycles, wipe_done_o pulses on cycle 128, busy_o falls; a read of addr 77 then returns 32'hA5A5A5A5.
- Ready: write addr 5 with 32'hDEADBEEF and wmask 32'h0000FFFF over a wipe of 0, then read addr 5 -> rvalid_o exactly 1 cycle later with rdata_o=32'h0000BEEF.
- Reads to addrs 1,2,3 on consecutive cycles -> rvalid_o high for 3 consecutive cycles with data in order.
- Depth=100: read addr 110 -> gnt_o=1, ram_req_o=0, next cycle rvalid_o=1, rerror_o=1, rdata_o=0; write to addr 120 leaves mem unchanged.
- Read of addr 3 granted in cycle N, wipe_req_i=1 in cycle N+1 with req_i=1 -> rvalid for addr 3 in N+1, gnt_o=0 in N+1, busy_o=1 from N+2.
- Reset deasserted for 40 cycles of wipe, then rst_ni pulsed low -> wipe restarts at addr 0 and completes after a further 128 cycles.
